// File: rtl/quaternion_addsub_pipe_if.sv
// quaternion_addsub_pipe_if: valid/ready quaternion bus between source, add/sub pipe and consumer.
interface quaternion_addsub_pipe_if #(parameter int W = 16);
    logic           in_valid, in_ready, in_op;
    logic [4*W-1:0] in_a, in_b;
    logic           out_valid, out_ready;
    logic [4*W-1:0] out_q;
    logic [3:0]     out_ovf;
    logic           ovf_sticky, ovf_clr;
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready, ovf_clr,
        input  in_ready, out_valid, out_q, out_ovf, ovf_sticky
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready, ovf_clr,
        output in_ready, out_valid, out_q, out_ovf, ovf_sticky
    );
endinterface

// File: rtl/quaternion_addsub_pipe.sv
// quaternion_addsub_pipe: LAT-stage quaternion add/sub with optional saturation and overflow flags.
module quaternion_addsub_pipe #(
    parameter int W   = 16,
    parameter int LAT = 2,
    parameter bit SAT = 1'b1
) (
    input logic                     clk,
    input logic                     rst,
    quaternion_addsub_pipe_if.slave bus
);
    logic [4*W-1:0] res;
    logic [3:0]     res_ovf;
    logic [LAT-1:0] v_q, v_d, ld;
    logic [4*W-1:0] q_q [LAT];
    logic [4*W-1:0] q_d [LAT];
    logic [3:0]     o_q [LAT];
    logic [3:0]     o_d [LAT];
    logic           sticky_q, sticky_d, all_v;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [W:0] s;
        assign s = bus.in_op
            ? {bus.in_a[i*W+W-1], bus.in_a[i*W +: W]} - {bus.in_b[i*W+W-1], bus.in_b[i*W +: W]}
            : {bus.in_a[i*W+W-1], bus.in_a[i*W +: W]} + {bus.in_b[i*W+W-1], bus.in_b[i*W +: W]};
        assign res_ovf[i] = s[W] ^ s[W-1];
        assign res[i*W +: W] = (SAT && res_ovf[i]) ? {s[W], {(W-1){!s[W]}}} : s[W-1:0];
    end

    // A stage may load unless it and every stage after it are full while the output stalls.
    always_comb begin
        all_v = 1'b1;
        for (int k = LAT - 1; k >= 0; k--) begin
            all_v = all_v & v_q[k];
            ld[k] = bus.out_ready | !all_v;
        end
        v_d[0] = ld[0] ? bus.in_valid : v_q[0];
        q_d[0] = ld[0] ? res : q_q[0];
        o_d[0] = ld[0] ? res_ovf : o_q[0];
        for (int k = 1; k < LAT; k++) begin
            v_d[k] = ld[k] ? v_q[k-1] : v_q[k];
            q_d[k] = ld[k] ? q_q[k-1] : q_q[k];
            o_d[k] = ld[k] ? o_q[k-1] : o_q[k];
        end
        sticky_d = (bus.out_valid & bus.out_ready & (|bus.out_ovf)) | (sticky_q & !bus.ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= '0;
            sticky_q <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                q_q[k] <= '0;
                o_q[k] <= '0;
            end
        end else begin
            v_q      <= v_d;
            sticky_q <= sticky_d;
            q_q      <= q_d;
            o_q      <= o_d;
        end
    end

    assign bus.in_ready   = ld[0];
    assign bus.out_valid  = v_q[LAT-1];
    assign bus.out_q      = q_q[LAT-1];
    assign bus.out_ovf    = o_q[LAT-1];
    assign bus.ovf_sticky = sticky_q;
endmodule
